// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
//
// Shared widths and payload layouts for the memory-access stage.
//   ES_TO_MS_DATA_WD   : execute -> memory payload width (76)
//   MS_TO_WS_DATA_WD   : memory -> write-back payload width (70)
//   MS_FWD_BLK_DATA_WD : forwarding/blocking bundle to decode width (42)
// The packed structs mirror the bit layouts of those buses, MSB first.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

   localparam int ES_TO_MS_DATA_WD   = 76;
   localparam int MS_TO_WS_DATA_WD   = 70;
   localparam int MS_FWD_BLK_DATA_WD = 42;

   // Field positions inside es_to_ms_data
   localparam int ES_LD_B_BIT      = 75;
   localparam int ES_LD_BU_BIT     = 74;
   localparam int ES_LD_H_BIT      = 73;
   localparam int ES_LD_HU_BIT     = 72;
   localparam int ES_LD_W_BIT      = 71;
   localparam int ES_RES_MEM_BIT   = 70;
   localparam int ES_GR_WE_BIT     = 69;

   // Execute -> memory payload: 76 bits
   typedef struct packed {
      logic        ld_b;
      logic        ld_bu;
      logic        ld_h;
      logic        ld_hu;
      logic        ld_w;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] exe_result;   // byte address for loads
      logic [31:0] pc;
   } es_to_ms_t;

   // Memory -> write-back payload: 70 bits
   typedef struct packed {
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ms_to_ws_t;

   // Forwarding / blocking bundle to decode: 42 bits
   typedef struct packed {
      logic [3:0]  fwd_valid;
      logic [4:0]  rf_dest;
      logic [31:0] rf_data;
      logic        blk_valid;
   } ms_fwd_blk_t;

endpackage

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
//
// Valid/allowin pipeline handshake carrying a WD-bit payload between two
// adjacent pipeline stages.
//   valid   : upstream payload is valid this cycle
//   data    : upstream payload
//   allowin : downstream can accept this cycle
// Modports:
//   master : upstream side (drives valid/data, receives allowin)
//   slave  : downstream side (receives valid/data, drives allowin)
// -----------------------------------------------------------------------------
interface mem_stage_if #(
   parameter int WD = 1
);

   logic          valid;
   logic [WD-1:0] data;
   logic          allowin;

   modport master (
      output valid,
      output data,
      input  allowin
   );

   modport slave (
      input  valid,
      input  data,
      output allowin
   );

endinterface

// File: rtl/mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
//
// Combinational load-data aligner. Picks the addressed byte or halfword out
// of a 32-bit memory word and sign- or zero-extends it.
//   word   in  32  raw memory word
//   a      in  2   byte offset (address bits [1:0])
//   ld_b   in  1   signed byte load
//   ld_bu  in  1   unsigned byte load
//   ld_h   in  1   signed halfword load
//   ld_hu  in  1   unsigned halfword load
//   ld_w   in  1   word load
//   result out 32  aligned, extended load value
// Halfword/word misalignment is not checked: a[0] is ignored for halfwords
// and a[1:0] is ignored for words.
// -----------------------------------------------------------------------------
module load_align (
   input  logic [31:0] word,
   input  logic [1:0]  a,
   input  logic        ld_b,
   input  logic        ld_bu,
   input  logic        ld_h,
   input  logic        ld_hu,
   input  logic        ld_w,
   output logic [31:0] result
);

   function automatic logic [31:0] sext8(input logic [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] zext8(input logic [7:0] b);
      return {24'h0, b};
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] h);
      return {{16{h[15]}}, h};
   endfunction

   function automatic logic [31:0] zext16(input logic [15:0] h);
      return {16'h0, h};
   endfunction

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[7:0];
      case (a)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
   end

   assign half_sel = a[1] ? word[31:16] : word[15:0];

   // The load flags are one-hot for a real load; with none set the raw word
   // passes through.
   always_comb begin
      result = word;
      if (ld_b)
         result = sext8(byte_sel);
      else if (ld_bu)
         result = zext8(byte_sel);
      else if (ld_h)
         result = sext16(half_sel);
      else if (ld_hu)
         result = zext16(half_sel);
      else if (ld_w)
         result = word;
   end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the five-stage in-order CPU. Latches the execute
// payload, takes the synchronous data-SRAM read response (valid in the first
// cycle the load sits in this stage), aligns/extends load data and hands the
// result to write-back. A one-entry read buffer keeps the SRAM response alive
// across write-back stalls. Also publishes forwarding/blocking info to decode.
//
// Ports:
//   clk              in   rising-edge clock
//   resetn           in   synchronous, active-low reset
//   es_ms            slave  handshake from execute
//                         (valid=es_to_ms_valid, data=es_to_ms_data[75:0],
//                          allowin=ms_allowin)
//   ms_ws            master handshake to write-back
//                         (valid=ms_to_ws_valid, data=ms_to_ws_data[69:0],
//                          allowin=ws_allowin)
//   data_sram_rdata  in   32  SRAM read data
//   ms_fwd_blk_data  out  42  {fwd_valid[3:0], rf_dest, rf_data, blk_valid}
//
// Configuration macro: MS_LOAD_FWD_EN
//   defined   : load results forward from this stage, never block decode.
//   undefined : loads in this stage block decode instead of forwarding,
//               keeping the SRAM read data off the decode bypass path.
// -----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                          clk,
   input  logic                          resetn,
   mem_stage_if.slave                    es_ms,
   mem_stage_if.master                   ms_ws,
   input  logic [31:0]                   data_sram_rdata,
   output logic [MS_FWD_BLK_DATA_WD-1:0] ms_fwd_blk_data
);

   es_to_ms_t   es_in;
   es_to_ms_t   ms_data;
   ms_to_ws_t   ms_out;
   ms_fwd_blk_t fwd_blk;

   logic        ms_valid;
   logic        ms_first;
   logic        ms_ready_go;
   logic        ms_allowin;
   logic        ws_allowin;
   logic        ms_accept;
   logic        ms_handoff;

   logic [31:0] rbuf;
   logic        rbuf_v;
   logic        rbuf_capture;

   logic [31:0] raw_word;
   logic [31:0] load_result;
   logic [31:0] final_result;
   logic        fwd_ok;

   assign es_in      = es_to_ms_t'(es_ms.data);
   assign ws_allowin = ms_ws.allowin;

   // Handshake: this stage always completes in one cycle.
   assign ms_ready_go = 1'b1;
   assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_accept   = es_ms.valid && ms_allowin;
   assign ms_handoff  = ms_valid && ms_ready_go && ws_allowin;

   // The SRAM response is only valid in the load's first cycle here; if
   // write-back is stalling then, park it before it disappears.
   assign rbuf_capture = ms_valid && ms_first && ms_data.res_from_mem && !ws_allowin;

   // ---- stage register: execute -> memory ----
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ms_valid <= 1'b0;
         ms_first <= 1'b0;
         rbuf_v   <= 1'b0;
         ms_data  <= '0;
      end else begin
         if (ms_allowin)
            ms_valid <= es_ms.valid;
         ms_first <= ms_accept;
         if (ms_accept)
            ms_data <= es_in;
         // Capture needs !ws_allowin and handoff needs ws_allowin, so the
         // two never coincide.
         if (ms_handoff)
            rbuf_v <= 1'b0;
         else if (rbuf_capture)
            rbuf_v <= 1'b1;
      end
   end

   // Buffer contents are qualified by rbuf_v, so they need no reset.
   always_ff @(posedge clk) begin
      if (rbuf_capture)
         rbuf <= data_sram_rdata;
   end

   // ---- memory-stage combinational result ----
   assign raw_word = rbuf_v ? rbuf : data_sram_rdata;

   load_align u_load_align (
      .word   (raw_word),
      .a      (ms_data.exe_result[1:0]),
      .ld_b   (ms_data.ld_b),
      .ld_bu  (ms_data.ld_bu),
      .ld_h   (ms_data.ld_h),
      .ld_hu  (ms_data.ld_hu),
      .ld_w   (ms_data.ld_w),
      .result (load_result)
   );

   assign final_result = ms_data.res_from_mem ? load_result : ms_data.exe_result;

   assign ms_out.gr_we        = ms_data.gr_we;
   assign ms_out.dest         = ms_data.dest;
   assign ms_out.final_result = final_result;
   assign ms_out.pc           = ms_data.pc;

   assign es_ms.allowin = ms_allowin;
   assign ms_ws.valid   = ms_valid && ms_ready_go;
   assign ms_ws.data    = ms_out;

   // ---- forwarding / blocking to decode ----
`ifdef MS_LOAD_FWD_EN
   assign fwd_ok            = 1'b1;
   assign fwd_blk.blk_valid = 1'b0;
`else
   assign fwd_ok            = !ms_data.res_from_mem;
   assign fwd_blk.blk_valid = ms_valid && ms_data.res_from_mem;
`endif

   assign fwd_blk.fwd_valid = {4{ms_valid && ms_data.gr_we && fwd_ok}};
   assign fwd_blk.rf_dest   = ms_data.dest;
   assign fwd_blk.rf_data   = final_result;

   assign ms_fwd_blk_data = fwd_blk;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Directed bench for mem_stage. Builds execute payloads, drives the SRAM read
// data in the load's first MEM cycle, and compares write-back and decode
// bundles against hand-computed values. Honours MS_LOAD_FWD_EN.
// -----------------------------------------------------------------------------
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk;
   logic        resetn;
   logic [31:0] data_sram_rdata;
   logic [41:0] ms_fwd_blk_data;

   int n_tests;
   int n_fail;

   mem_stage_if #(.WD(ES_TO_MS_DATA_WD)) es_ms ();
   mem_stage_if #(.WD(MS_TO_WS_DATA_WD)) ms_ws ();

   mem_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .es_ms           (es_ms),
      .ms_ws           (ms_ws),
      .data_sram_rdata (data_sram_rdata),
      .ms_fwd_blk_data (ms_fwd_blk_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected decode-side signals for a load sitting in MEM
`ifdef MS_LOAD_FWD_EN
   localparam logic [3:0] LD_FWD = 4'hF;
   localparam logic       LD_BLK = 1'b0;
`else
   localparam logic [3:0] LD_FWD = 4'h0;
   localparam logic       LD_BLK = 1'b1;
`endif

   function automatic logic [75:0] mk(input logic [4:0]  ld,
                                      input logic        rfm,
                                      input logic        we,
                                      input logic [4:0]  dest,
                                      input logic [31:0] exe,
                                      input logic [31:0] pc);
      return {ld, rfm, we, dest, exe, pc};
   endfunction

   task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Latch one payload, then drop es_to_ms_valid.
   task automatic issue(input logic [75:0] d);
      es_ms.valid = 1'b1;
      es_ms.data  = d;
      tick();
      es_ms.valid = 1'b0;
   endtask

   // Check the result / forwarding view of the instruction in MEM.
   task automatic chk_out(input string tag, input logic [4:0] dest,
                          input logic [31:0] res, input logic [31:0] pc,
                          input logic [3:0] fwd, input logic blk);
      chk({tag, " valid"},    76'(ms_ws.valid),               76'(1'b1));
      chk({tag, " result"},   76'(ms_ws.data[63:32]),         76'(res));
      chk({tag, " dest"},     76'(ms_ws.data[68:64]),         76'(dest));
      chk({tag, " pc"},       76'(ms_ws.data[31:0]),          76'(pc));
      chk({tag, " fwd"},      76'(ms_fwd_blk_data[41:38]),    76'(fwd));
      chk({tag, " blk"},      76'(ms_fwd_blk_data[0]),        76'(blk));
      chk({tag, " rf_data"},  76'(ms_fwd_blk_data[32:1]),     76'(res));
   endtask

   // Load opcodes {ld_b, ld_bu, ld_h, ld_hu, ld_w}
   localparam logic [4:0] LB  = 5'b10000;
   localparam logic [4:0] LBU = 5'b01000;
   localparam logic [4:0] LH  = 5'b00100;
   localparam logic [4:0] LHU = 5'b00010;
   localparam logic [4:0] LW  = 5'b00001;

   initial begin
      n_tests         = 0;
      n_fail          = 0;
      resetn          = 1'b0;
      es_ms.valid     = 1'b0;
      es_ms.data      = '0;
      ms_ws.allowin   = 1'b1;
      data_sram_rdata = 32'h0;

      // ---- reset state ----
      tick();
      tick();
      chk("rst allowin", 76'(es_ms.allowin),   76'(1'b1));
      chk("rst valid",   76'(ms_ws.valid),     76'(1'b0));
      chk("rst ws_data", 76'(ms_ws.data),      76'(0));
      chk("rst fwdblk",  76'(ms_fwd_blk_data), 76'(0));
      resetn = 1'b1;

      // ---- byte loads, a = 3 ----
      issue(mk(LB, 1'b1, 1'b1, 5'd3, 32'h0000_1003, 32'h0000_0100));
      data_sram_rdata = 32'h80FF_1234;
      #1;
      chk_out("ld_b a3", 5'd3, 32'hFFFF_FF80, 32'h0000_0100, LD_FWD, LD_BLK);

      issue(mk(LBU, 1'b1, 1'b1, 5'd3, 32'h0000_1003, 32'h0000_0104));
      data_sram_rdata = 32'h80FF_1234;
      #1;
      chk_out("ld_bu a3", 5'd3, 32'h0000_0080, 32'h0000_0104, LD_FWD, LD_BLK);

      // ---- halfword loads, a = 2 ----
      issue(mk(LH, 1'b1, 1'b1, 5'd7, 32'h0000_2002, 32'h0000_0108));
      data_sram_rdata = 32'h8001_7FFF;
      #1;
      chk_out("ld_h a2", 5'd7, 32'hFFFF_8001, 32'h0000_0108, LD_FWD, LD_BLK);

      issue(mk(LHU, 1'b1, 1'b1, 5'd7, 32'h0000_2002, 32'h0000_010C));
      data_sram_rdata = 32'h8001_7FFF;
      #1;
      chk("ld_hu a2", 76'(ms_ws.data[63:32]), 76'(32'h0000_8001));

      // ---- other offsets ----
      issue(mk(LB, 1'b1, 1'b1, 5'd8, 32'h0000_2000, 32'h0000_0110));
      data_sram_rdata = 32'h8001_7FFF;
      #1;
      chk("ld_b a0", 76'(ms_ws.data[63:32]), 76'(32'hFFFF_FFFF));

      issue(mk(LBU, 1'b1, 1'b1, 5'd8, 32'h0000_2001, 32'h0000_0114));
      data_sram_rdata = 32'h8001_7FFF;
      #1;
      chk("ld_bu a1", 76'(ms_ws.data[63:32]), 76'(32'h0000_007F));

      issue(mk(LH, 1'b1, 1'b1, 5'd8, 32'h0000_2000, 32'h0000_0118));
      data_sram_rdata = 32'h8001_7FFF;
      #1;
      chk("ld_h a0", 76'(ms_ws.data[63:32]), 76'(32'h0000_7FFF));

      // ---- bubble ----
      tick();
      chk("bubble valid", 76'(ms_ws.valid),            76'(1'b0));
      chk("bubble fwd",   76'(ms_fwd_blk_data[41:38]), 76'(4'h0));
      chk("bubble blk",   76'(ms_fwd_blk_data[0]),     76'(1'b0));

      // ---- stalled ld_w: result must survive SRAM data changing ----
      ms_ws.allowin = 1'b0;
      issue(mk(LW, 1'b1, 1'b1, 5'd5, 32'h0000_3000, 32'h0000_0200));
      data_sram_rdata = 32'hDEAD_BEEF;
      // An ALU op waits upstream; it must not enter during the stall.
      es_ms.valid = 1'b1;
      es_ms.data  = mk(5'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0055, 32'h0000_0204);
      #1;
      chk_out("stall c0", 5'd5, 32'hDEAD_BEEF, 32'h0000_0200, LD_FWD, LD_BLK);
      chk("stall c0 allowin", 76'(es_ms.allowin), 76'(1'b0));
      for (int c = 1; c <= 3; c++) begin
         tick();
         data_sram_rdata = 32'h0;
         #1;
         chk($sformatf("stall c%0d result", c),  76'(ms_ws.data[63:32]), 76'(32'hDEAD_BEEF));
         chk($sformatf("stall c%0d pc", c),      76'(ms_ws.data[31:0]),  76'(32'h0000_0200));
         chk($sformatf("stall c%0d allowin", c), 76'(es_ms.allowin),     76'(1'b0));
         chk($sformatf("stall c%0d valid", c),   76'(ms_ws.valid),       76'(1'b1));
         chk($sformatf("stall c%0d rbuf_v", c),  76'(dut.rbuf_v),        76'(1'b1));
      end

      // ---- release: load hands off, waiting ALU op enters behind it ----
      ms_ws.allowin = 1'b1;
      #1;
      chk("release allowin", 76'(es_ms.allowin), 76'(1'b1));
      tick();
      es_ms.valid = 1'b0;
      chk("release rbuf_v", 76'(dut.rbuf_v), 76'(1'b0));
      chk_out("after stall alu", 5'd9, 32'h0000_0055, 32'h0000_0204, 4'hF, 1'b0);
      tick();
      chk("drained valid", 76'(ms_ws.valid), 76'(1'b0));

      // ---- back-to-back ld_w (r5) then ALU add (r6 = 7) ----
      issue(mk(LW, 1'b1, 1'b1, 5'd5, 32'h0000_4004, 32'h0000_0300));
      data_sram_rdata = 32'h1234_5678;
      es_ms.valid = 1'b1;
      es_ms.data  = mk(5'b0, 1'b0, 1'b1, 5'd6, 32'h0000_0007, 32'h0000_0304);
      #1;
      chk_out("b2b ld_w", 5'd5, 32'h1234_5678, 32'h0000_0300, LD_FWD, LD_BLK);
      tick();
      es_ms.valid     = 1'b0;
      data_sram_rdata = 32'hFFFF_FFFF;
      #1;
      chk_out("b2b add", 5'd6, 32'h0000_0007, 32'h0000_0304, 4'hF, 1'b0);
      chk("b2b add first", 76'(dut.ms_first), 76'(1'b1));

      // ---- non-writing op: no forwarding ----
      issue(mk(5'b0, 1'b0, 1'b0, 5'd10, 32'h0000_00AA, 32'h0000_0308));
      #1;
      chk("no_we fwd", 76'(ms_fwd_blk_data[41:38]), 76'(4'h0));

      // ---- reset during a stalled load ----
      tick();
      ms_ws.allowin = 1'b0;
      issue(mk(LW, 1'b1, 1'b1, 5'd4, 32'h0000_5000, 32'h0000_0400));
      data_sram_rdata = 32'hAAAA_5555;
      #1;
      chk("pre-rst result", 76'(ms_ws.data[63:32]), 76'(32'hAAAA_5555));
      tick();
      resetn = 1'b0;
      tick();
      chk("mid-rst valid",   76'(ms_ws.valid),     76'(1'b0));
      chk("mid-rst allowin", 76'(es_ms.allowin),   76'(1'b1));
      chk("mid-rst rbuf_v",  76'(dut.rbuf_v),      76'(1'b0));
      chk("mid-rst ws_data", 76'(ms_ws.data),      76'(0));
      chk("mid-rst fwdblk",  76'(ms_fwd_blk_data), 76'(0));
      resetn        = 1'b1;
      ms_ws.allowin = 1'b1;
      issue(mk(LW, 1'b1, 1'b1, 5'd4, 32'h0000_5000, 32'h0000_0500));
      data_sram_rdata = 32'h0BAD_F00D;
      #1;
      chk_out("post-rst ld_w", 5'd4, 32'h0BAD_F00D, 32'h0000_0500, LD_FWD, LD_BLK);

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage in-order CPU, directly downstream of the execute stage and upstream of write-back. Latches the execute-stage payload and takes the synchronous data-SRAM read response (valid the cycle after the execute stage issued the address). Aligns and sign/zero-extends load data, then hands the final result to write-back. Holds the SRAM response in a one-entry buffer so stalls from write-back never lose load data, and publishes forwarding/blocking information to decode.

## Interface
- Parameters: none; widths come from `mycpu.vh`: `ES_TO_MS_DATA_WD`=76, `MS_TO_WS_DATA_WD`=70, `MS_FWD_BLK_DATA_WD`=42.
- One clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock.
- resetn  in  1  synchronous, active-low reset.
- ws_allowin  in  1  write-back can accept this cycle.
- ms_allowin  out  1  this stage can accept this cycle.
- es_to_ms_valid  in  1  execute payload valid.
- es_to_ms_data  in  76  fields, MSB first:
  - {ld_b, ld_bu, ld_h, ld_hu, ld_w} [75:71]
  - res_from_mem [70]
  - gr_we [69]
  - dest [68:64]
  - exe_result [63:32], which is the byte address for loads
  - pc [31:0]
- data_sram_rdata  in  32  SRAM read data, valid in first MS cycle of a load only.
- ms_to_ws_valid  out  1  payload to write-back valid.
- ms_to_ws_data  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- ms_fwd_blk_data  out  42  {fwd_valid[41:38], rf_dest[37:33], rf_data[32:1], blk_valid[0]}.

## Operation
- Pipeline register:
  - On `es_to_ms_valid && ms_allowin`, latch `es_to_ms_data`.
  - When `ms_allowin`, `ms_valid <= es_to_ms_valid`.
- Control:
  - ms_ready_go = 1.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid.
- First-cycle flag `ms_first`:
  - Set when a new payload is latched.
  - Cleared on any clock where no new payload enters.
- Read buffer `rbuf` with valid bit `rbuf_v`:
  - Capture: if `ms_valid && ms_first && res_from_mem && !ws_allowin`, then `rbuf <= data_sram_rdata` and `rbuf_v <= 1`.
  - Clear: when the stage hands off (`ms_valid && ws_allowin`), `rbuf_v <= 0`.
  - Capture and handoff in the same cycle cannot occur, by construction.
- Raw word = rbuf_v ? rbuf : data_sram_rdata.
- Alignment, with a = exe_result[1:0]:
  - byte = word[8a+7:8a]; half = a[1] ? word[31:16] : word[15:0].
  - ld_b sign-extends byte; ld_bu zero-extends byte.
  - ld_h sign-extends half; ld_hu zero-extends half.
  - ld_w passes the word through.
  - Misaligned h/w addresses are not checked; low bits are ignored as above.
- final_result = res_from_mem ? aligned load : exe_result.
- Forwarding:
  - rf_dest = dest.
  - rf_data = final_result.
  - fwd_valid = {4{ms_valid && gr_we && fwd_ok}}; fwd_ok is defined under Configuration.
- No flush input; this stage never cancels an instruction.

## Timing
- Reset (resetn=0 at a clock edge):
  - Clears ms_valid, ms_first, rbuf_v, and the payload register, so every output field is 0.
  - After reset: ms_allowin=1, ms_to_ws_valid=0, fwd_valid=0, blk_valid=0.
  - Reset mid-load discards the load and its buffered data.
- Latency is one cycle: payload latched at edge N appears on ms_to_ws_* during cycle N+1.
- Stall:
  - While ws_allowin=0 and ms_valid=1, ms_allowin=0 and all outputs hold stable.
  - Load results are taken from rbuf from the second stall cycle on.
- Back-to-back: handoff and a new latch occur on the same edge; ms_first reasserts for the new payload.
- Bubble: if es_to_ms_valid=0 while ms_allowin=1, ms_valid drops next cycle and fwd_valid=0.

## Configuration
- `MS_LOAD_FWD_EN` defined:
  - fwd_ok = 1, so load results forward from this stage.
  - blk_valid = 0.
- `MS_LOAD_FWD_EN` undefined:
  - fwd_ok = !res_from_mem.
  - blk_valid = ms_valid && res_from_mem, so decode stalls on a load in MEM.
  - This shortens the SRAM-to-decode path.

## Structure
- `mycpu.vh` holds the three width defines and the field bit positions.
- Sub-module `load_align` (combinational): inputs word[31:0], a[1:0] and the five ld flags; output result[31:0].
- The stage module holds the registers, handshake and buffer.

## Test plan
- ld_b, addr low bits 2'b11, rdata=32'h80FF_1234, ws_allowin=1: final_result=32'hFFFF_FF80 one cycle later; ld_bu gives 32'h0000_0080.
- ld_h, a=2'b10, rdata=32'h8001_7FFF: final_result=32'hFFFF_8001; ld_hu gives 32'h0000_8001.
- ld_w with rdata=32'hDEAD_BEEF:
  - Hold ws_allowin=0 for 3 cycles while rdata changes to 32'h0; final_result stays 32'hDEAD_BEEF.
  - ms_allowin=0 throughout the stall.
  - Release: one handoff, then rbuf_v=0.
- Back-to-back ld_w (dest 5) then ALU add (dest 6, exe_result=7): consecutive ms_to_ws_valid cycles with correct results; fwd_valid=4'hF for both when `MS_LOAD_FWD_EN` is defined.
- `MS_LOAD_FWD_EN` undefined, load to r4 in MEM: fwd_valid=0, blk_valid=1; ALU op in MEM: fwd_valid=4'hF, blk_valid=0.
- resetn=0 during a stalled load: next cycle ms_to_ws_valid=0, ms_allowin=1, rbuf_v=0; first instruction after reset does not use stale rbuf.
